mac_multi_fsm: RTL and testbench
================================

// Module: mac_multi_fsm
// PURPOSE
//  Parametrised control FSM for a MAC engine with N_SRC source streams and one sink stream.
//  Supports three modes: MUL, MAC and MAC_BIAS. Iterates internally with per-channel base+stride addressing, so no ucode is needed.
//  Adds a compute watchdog and an abort input, and reports completion with an error flag.
//  Sits between the slave register file, the streamer and the MAC engine.
// PARAMETERS
//  N_SRC   3   source channels (>=2); channel N_SRC-1 is the bias/accumulator-init source
//  ADDR_W  32  byte-address width of base/stride/address outputs
//  LEN_W   16  width of job length / transfer size
//  ITER_W  16  width of iteration count
//  TMO_W   16  width of watchdog timeout
// PORTS
//  clk_i              in   1            clock
//  rst_i              in   1            async reset, active-high
//  clear_i            in   1            sync soft clear; same effect as reset
//  start_i            in   1            job start pulse; honoured only in IDLE
//  abort_i            in   1            job abort; honoured in START/WAIT/COMPUTE/UPDATE
//  cfg_mode_i         in   2            0 MUL, 1 MAC, 2 MAC_BIAS, 3 illegal
//  cfg_len_i          in   LEN_W        elements per iteration
//  cfg_n_iter_i       in   ITER_W       iterations per job
//  cfg_timeout_i      in   TMO_W        max COMPUTE cycles without acc_done; 0 = disabled
//  cfg_base_i         in   (N_SRC+1)*ADDR_W  base address per channel; sink in top slice
//  cfg_stride_i       in   (N_SRC+1)*ADDR_W  per-iteration address stride per channel
//  src_ready_start_i  in   N_SRC        source streamer ready
//  src_req_start_o    out  N_SRC        source start pulse
//  src_addr_o         out  N_SRC*ADDR_W current source base address
//  src_size_o         out  N_SRC*LEN_W  source transfer size
//  snk_ready_start_i  in   1            sink streamer ready
//  snk_req_start_o    out  1            sink start pulse
//  snk_addr_o         out  ADDR_W       current sink base address
//  snk_size_o         out  LEN_W        sink transfer size
//  eng_start_o        out  1            engine start pulse
//  eng_clear_o        out  1            engine clear
//  eng_enable_o       out  1            engine enable
//  eng_acc_done_i     in   1            engine iteration complete
//  busy_o             out  1            state != IDLE
//  done_o             out  1            job-complete pulse, 1 cycle
//  evt_o              out  1            iteration-complete pulse (UPDATE cycle)
//  err_o              out  1            sticky error; cleared on next accepted start
//  state_o            out  3            current state encoding
//  iter_o             out  ITER_W       completed-iteration count
// BEHAVIOUR
//  Reset/clear: state IDLE; iter, offsets and watchdog = 0; err_o = 0.
//   All pulse outputs are 0; eng_clear_o = 1; eng_enable_o = 1.
//  Config: latched when start_i is accepted in IDLE; cfg_* changes during a job are ignored.
//  Enabled set: all sources plus sink. Source N_SRC-1 is excluded unless mode = MAC_BIAS.
//   An excluded channel's ready is ignored and its req_start stays 0.
//  Sizes: sources = len; bias source = 1; sink = len in MUL mode, else 1.
//  Addresses: addr = base + offs, computed combinationally from registered values.
//   offs += stride in each UPDATE; arithmetic wraps modulo 2^ADDR_W.
//  States and transitions:
//   IDLE(0): eng_clear = 1. On start: err := 0, iter := 0, offs := 0. Then:
//    mode = 3 or len = 0 -> TERMINATE with err := 1;
//    n_iter = 0 -> TERMINATE;
//    else -> START.
//   START(1)/WAIT(2): when all enabled channels are ready, in the same cycle:
//    pulse req_start on enabled channels and eng_start; eng_clear = 0; go to COMPUTE.
//    Otherwise START goes to WAIT, and WAIT holds with eng_enable = 0 and eng_clear = 0.
//   COMPUTE(3): eng_clear = 0; watchdog counts up each cycle.
//    acc_done -> UPDATE.
//    Watchdog reaches cfg_timeout (nonzero) -> TERMINATE with err := 1.
//    Watchdog resets on entering COMPUTE.
//   UPDATE(4): 1 cycle. iter += 1; offs += stride; evt_o = 1.
//    If iter+1 = n_iter -> TERMINATE, else -> WAIT.
//   TERMINATE(5): eng_enable = 0. When all enabled channels are ready:
//    done_o = 1 for one cycle, then go to IDLE.
//  Priority: reset > clear_i > abort_i > acc_done/timeout.
//   abort_i -> TERMINATE with err := 1. start_i outside IDLE is ignored.
//   Abort in the same cycle as start is ignored, because abort is not honoured in IDLE.
//  Latency: start to first req_start is 1 cycle if all channels are ready.
//   acc_done to next req_start is 2 cycles (UPDATE, then WAIT).
// STRUCTURE
//  Package mac_multi_package: mode enum; state enum; default N_SRC, ADDR_W and LEN_W constants.
//  Sub-module mac_multi_addr_gen (per channel): latches base and stride, accumulates offs, outputs addr.
//   Instantiated N_SRC+1 times in a generate loop.
// TESTING
//  MAC, N_SRC=3, len=8, n_iter=4, strides 32/32/0/4, all ready -> 4 evt pulses, 1 done;
//   sink addr steps +4; bias source never started.
//  MUL, len=16, n_iter=1 -> sink size 16; done 1 cycle after ready in TERMINATE; err 0.
//  MAC_BIAS with src2 ready held low 5 cycles -> FSM stays in WAIT with eng_enable 0;
//   all channels pulse together on release.
//  timeout=10, acc_done never asserted -> TERMINATE at 10th COMPUTE cycle; done with err_o = 1.
//  abort in COMPUTE, same cycle as acc_done -> TERMINATE, err 1, no evt.
//   Next start clears err.
//  mode=3 or len=0 -> no req_start issued; done and err_o = 1.
//   Stride 0xFFFF_FFF0 wraps addr; reset mid-job -> IDLE, all pulses 0.

Source files
------------

// File: rtl/mac_multi_fsm_pkg.sv
// Shared types and default sizes for the multi-source MAC controller.
package mac_multi_package;

    localparam int DEF_N_SRC  = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {
        MODE_MUL      = 2'd0,
        MODE_MAC      = 2'd1,
        MODE_MAC_BIAS = 2'd2,
        MODE_ILLEGAL  = 2'd3
    } mode_e;

    // state     | meaning
    // IDLE      | waiting for start, engine held clear
    // START     | first attempt to launch all enabled channels
    // WAIT      | launch pending on channel readiness, engine paused
    // COMPUTE   | engine running one iteration, watchdog active
    // UPDATE    | iteration retired, offsets advanced
    // TERMINATE | draining until channels are ready, then report done
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_COMPUTE   = 3'd3,
        ST_UPDATE    = 3'd4,
        ST_TERMINATE = 3'd5
    } state_e;

endpackage

// File: rtl/mac_multi_addr_gen.sv
// Per-channel address generator: base + accumulated stride offset.
module mac_multi_addr_gen
    import mac_multi_package::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_offs;

    // Latch base/stride at job start; advance the offset once per retired iteration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_base   <= '0;
            r_stride <= '0;
            r_offs   <= '0;
        end else if (clear_i) begin
            r_base   <= '0;
            r_stride <= '0;
            r_offs   <= '0;
        end else if (load_i) begin
            r_base   <= base_i;
            r_stride <= stride_i;
            r_offs   <= '0;
        end else if (step_i) begin
            r_offs   <= r_offs + r_stride;
        end
    end

    // Address wraps naturally modulo 2^ADDR_W.
    assign addr_o = r_base + r_offs;

endmodule

// File: rtl/mac_multi_fsm.sv
// Control FSM for a MAC engine fed by N_SRC source streams and one sink stream.
module mac_multi_fsm
    import mac_multi_package::*;
#(
    parameter int N_SRC  = DEF_N_SRC,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int ITER_W = 16,
    parameter int TMO_W  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [1:0]                 cfg_mode_i,
    input  logic [LEN_W-1:0]           cfg_len_i,
    input  logic [ITER_W-1:0]          cfg_n_iter_i,
    input  logic [TMO_W-1:0]           cfg_timeout_i,
    input  logic [(N_SRC+1)*ADDR_W-1:0] cfg_base_i,
    input  logic [(N_SRC+1)*ADDR_W-1:0] cfg_stride_i,
    input  logic [N_SRC-1:0]           src_ready_start_i,
    output logic [N_SRC-1:0]           src_req_start_o,
    output logic [N_SRC*ADDR_W-1:0]    src_addr_o,
    output logic [N_SRC*LEN_W-1:0]     src_size_o,
    input  logic                       snk_ready_start_i,
    output logic                       snk_req_start_o,
    output logic [ADDR_W-1:0]          snk_addr_o,
    output logic [LEN_W-1:0]           snk_size_o,
    output logic                       eng_start_o,
    output logic                       eng_clear_o,
    output logic                       eng_enable_o,
    input  logic                       eng_acc_done_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       evt_o,
    output logic                       err_o,
    output logic [2:0]                 state_o,
    output logic [ITER_W-1:0]          iter_o
);

    state_e             r_state;
    state_e             w_state_nxt;
    mode_e              r_mode;
    logic [LEN_W-1:0]   r_len;
    logic [ITER_W-1:0]  r_n_iter;
    logic [ITER_W-1:0]  r_iter;
    logic [TMO_W-1:0]   r_timeout;
    logic [TMO_W-1:0]   r_wd;
    logic               r_err;

    logic [N_SRC-1:0]   w_src_en;
    logic               w_all_ready;
    logic [TMO_W:0]     w_wd_inc;
    logic               w_timeout_hit;
    logic [ITER_W-1:0]  w_iter_inc;
    logic               w_load;
    logic               w_step;
    logic               w_err_set;
    logic [ADDR_W-1:0]  w_addr [0:N_SRC];

    // The bias source only takes part in MAC_BIAS jobs; the sink always does.
    always_comb begin
        w_src_en           = '1;
        w_src_en[N_SRC-1]  = (r_mode == MODE_MAC_BIAS);
    end

    assign w_all_ready   = snk_ready_start_i & (&(src_ready_start_i | ~w_src_en));
    assign w_wd_inc      = {1'b0, r_wd} + {{TMO_W{1'b0}}, 1'b1};
    assign w_timeout_hit = (r_timeout != '0) && (w_wd_inc == {1'b0, r_timeout});
    assign w_iter_inc    = r_iter + {{(ITER_W-1){1'b0}}, 1'b1};

    // Next-state and pulse decode; abort wins over acc_done and timeout.
    always_comb begin
        w_state_nxt     = r_state;
        src_req_start_o = '0;
        snk_req_start_o = 1'b0;
        eng_start_o     = 1'b0;
        eng_clear_o     = 1'b0;
        eng_enable_o    = 1'b1;
        done_o          = 1'b0;
        evt_o           = 1'b0;
        w_load          = 1'b0;
        w_step          = 1'b0;
        w_err_set       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                eng_clear_o = 1'b1;
                if (start_i) begin
                    w_load = 1'b1;
                    if ((cfg_mode_i == MODE_ILLEGAL) || (cfg_len_i == '0)) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = ST_TERMINATE;
                    end else if (cfg_n_iter_i == '0) begin
                        w_state_nxt = ST_TERMINATE;
                    end else begin
                        w_state_nxt = ST_START;
                    end
                end
            end
            ST_START, ST_WAIT: begin
                if (abort_i) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_TERMINATE;
                end else if (w_all_ready) begin
                    src_req_start_o = w_src_en;
                    snk_req_start_o = 1'b1;
                    eng_start_o     = 1'b1;
                    w_state_nxt     = ST_COMPUTE;
                end else if (r_state == ST_START) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    eng_enable_o = 1'b0;
                end
            end
            ST_COMPUTE: begin
                if (abort_i) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_TERMINATE;
                end else if (eng_acc_done_i) begin
                    w_state_nxt = ST_UPDATE;
                end else if (w_timeout_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_TERMINATE;
                end
            end
            ST_UPDATE: begin
                if (abort_i) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_TERMINATE;
                end else begin
                    w_step      = 1'b1;
                    evt_o       = 1'b1;
                    w_state_nxt = (w_iter_inc == r_n_iter) ? ST_TERMINATE : ST_WAIT;
                end
            end
            ST_TERMINATE: begin
                eng_enable_o = 1'b0;
                if (w_all_ready) begin
                    done_o      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latched job configuration, iteration count, watchdog and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_MUL;
            r_len     <= '0;
            r_n_iter  <= '0;
            r_timeout <= '0;
            r_iter    <= '0;
            r_wd      <= '0;
            r_err     <= 1'b0;
        end else if (clear_i) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_MUL;
            r_len     <= '0;
            r_n_iter  <= '0;
            r_timeout <= '0;
            r_iter    <= '0;
            r_wd      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mode    <= mode_e'(cfg_mode_i);
                r_len     <= cfg_len_i;
                r_n_iter  <= cfg_n_iter_i;
                r_timeout <= cfg_timeout_i;
                r_iter    <= '0;
                r_err     <= w_err_set;
            end else begin
                if (w_step)
                    r_iter <= w_iter_inc;
                if (w_err_set)
                    r_err <= 1'b1;
            end
            // Held at zero outside COMPUTE so each iteration starts a fresh count.
            r_wd <= (r_state == ST_COMPUTE) ? w_wd_inc[TMO_W-1:0] : '0;
        end
    end

    genvar gc;
    for (gc = 0; gc <= N_SRC; gc++) begin : g_ch
        mac_multi_addr_gen #(
            .ADDR_W (ADDR_W)
        ) u_addr_gen (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (clear_i),
            .load_i   (w_load),
            .step_i   (w_step),
            .base_i   (cfg_base_i[gc*ADDR_W +: ADDR_W]),
            .stride_i (cfg_stride_i[gc*ADDR_W +: ADDR_W]),
            .addr_o   (w_addr[gc])
        );
    end

    for (gc = 0; gc < N_SRC; gc++) begin : g_src_out
        assign src_addr_o[gc*ADDR_W +: ADDR_W] = w_addr[gc];
        if (gc == N_SRC-1) begin : g_bias
            assign src_size_o[gc*LEN_W +: LEN_W] = {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin : g_data
            assign src_size_o[gc*LEN_W +: LEN_W] = r_len;
        end
    end

    assign snk_addr_o = w_addr[N_SRC];
    assign snk_size_o = (r_mode == MODE_MUL) ? r_len : {{(LEN_W-1){1'b0}}, 1'b1};
    assign busy_o     = (r_state != ST_IDLE);
    assign err_o      = r_err;
    assign state_o    = r_state;
    assign iter_o     = r_iter;

endmodule

// File: tb/tb_mac_multi_fsm.sv
// Directed self-checking bench for mac_multi_fsm with default parameters.
module tb_mac_multi_fsm;

    logic         clk_i;
    logic         rst_i;
    logic         clear_i;
    logic         start_i;
    logic         abort_i;
    logic [1:0]   cfg_mode_i;
    logic [15:0]  cfg_len_i;
    logic [15:0]  cfg_n_iter_i;
    logic [15:0]  cfg_timeout_i;
    logic [127:0] cfg_base_i;
    logic [127:0] cfg_stride_i;
    logic [2:0]   src_ready_start_i;
    logic [2:0]   src_req_start_o;
    logic [95:0]  src_addr_o;
    logic [47:0]  src_size_o;
    logic         snk_ready_start_i;
    logic         snk_req_start_o;
    logic [31:0]  snk_addr_o;
    logic [15:0]  snk_size_o;
    logic         eng_start_o;
    logic         eng_clear_o;
    logic         eng_enable_o;
    logic         eng_acc_done_i;
    logic         busy_o;
    logic         done_o;
    logic         evt_o;
    logic         err_o;
    logic [2:0]   state_o;
    logic [15:0]  iter_o;

    int n_cmp = 0;
    int n_mis = 0;

    mac_multi_fsm dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .clear_i           (clear_i),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .cfg_mode_i        (cfg_mode_i),
        .cfg_len_i         (cfg_len_i),
        .cfg_n_iter_i      (cfg_n_iter_i),
        .cfg_timeout_i     (cfg_timeout_i),
        .cfg_base_i        (cfg_base_i),
        .cfg_stride_i      (cfg_stride_i),
        .src_ready_start_i (src_ready_start_i),
        .src_req_start_o   (src_req_start_o),
        .src_addr_o        (src_addr_o),
        .src_size_o        (src_size_o),
        .snk_ready_start_i (snk_ready_start_i),
        .snk_req_start_o   (snk_req_start_o),
        .snk_addr_o        (snk_addr_o),
        .snk_size_o        (snk_size_o),
        .eng_start_o       (eng_start_o),
        .eng_clear_o       (eng_clear_o),
        .eng_enable_o      (eng_enable_o),
        .eng_acc_done_i    (eng_acc_done_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .evt_o             (evt_o),
        .err_o             (err_o),
        .state_o           (state_o),
        .iter_o            (iter_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Next cycle begins at the falling edge; start is a single-cycle pulse.
    task automatic cyc();
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic kick(input logic [1:0] m, input logic [15:0] len,
                        input logic [15:0] niter, input logic [15:0] tmo);
        @(negedge clk_i);
        cfg_mode_i    = m;
        cfg_len_i     = len;
        cfg_n_iter_i  = niter;
        cfg_timeout_i = tmo;
        start_i       = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        src_ready_start_i = 3'b111;
        snk_ready_start_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        n_cmp++;
        if ({state_o, busy_o, err_o, done_o, evt_o, eng_start_o, eng_clear_o, eng_enable_o}
            !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_mis++;
            $display("FAIL reset_ctrl: got %b want %b",
                {state_o, busy_o, err_o, done_o, evt_o, eng_start_o, eng_clear_o, eng_enable_o}, 10'b0000000011);
        end
        n_cmp++;
        if ({src_req_start_o, snk_req_start_o, iter_o} !== 20'd0) begin
            n_mis++;
            $display("FAIL reset_req_iter: got %h want 0", {src_req_start_o, snk_req_start_o, iter_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_mac();
        int req_n = 0, evt_n = 0, done_n = 0, bias_n = 0, done_k = -1;
        logic [31:0] exp_snk, exp_src0;
        cfg_base_i   = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        cfg_stride_i = {32'd4, 32'd0, 32'd32, 32'd32};
        src_ready_start_i = 3'b111;
        snk_ready_start_i = 1'b1;
        eng_acc_done_i = 1'b1;
        kick(2'd1, 16'd8, 16'd4, 16'd0);
        for (int k = 0; k < 40 && done_n == 0; k++) begin
            cyc();
            #1;
            if (k == 0) begin
                n_cmp++;
                if ({state_o, src_req_start_o, snk_req_start_o, eng_start_o, src_size_o, snk_size_o}
                    !== {3'd1, 3'b011, 1'b1, 1'b1, 16'd1, 16'd8, 16'd8, 16'd1}) begin
                    n_mis++;
                    $display("FAIL mac_first_launch: got %h want %h",
                        {state_o, src_req_start_o, snk_req_start_o, eng_start_o, src_size_o, snk_size_o},
                        {3'd1, 3'b011, 1'b1, 1'b1, 16'd1, 16'd8, 16'd8, 16'd1});
                end
            end
            if (snk_req_start_o) begin
                exp_snk  = 32'h0000_4000 + 32'd4 * req_n;
                exp_src0 = 32'h0000_1000 + 32'd32 * req_n;
                n_cmp++;
                if ({snk_addr_o, src_addr_o[31:0]} !== {exp_snk, exp_src0}) begin
                    n_mis++;
                    $display("FAIL mac_addr[%0d]: got %h want %h", req_n,
                        {snk_addr_o, src_addr_o[31:0]}, {exp_snk, exp_src0});
                end
                n_cmp++;
                if (k != 3 * req_n) begin
                    n_mis++;
                    $display("FAIL mac_req_cycle[%0d]: got %0d want %0d", req_n, k, 3 * req_n);
                end
                req_n++;
            end
            if (src_req_start_o[2]) bias_n++;
            if (evt_o) evt_n++;
            if (done_o) begin
                done_n++;
                done_k = k;
                n_cmp++;
                if ({err_o, iter_o} !== {1'b0, 16'd4}) begin
                    n_mis++;
                    $display("FAIL mac_done_state: got %h want %h", {err_o, iter_o}, {1'b0, 16'd4});
                end
            end
        end
        n_cmp++;
        if ({req_n, evt_n, done_n, bias_n, done_k} !== {32'd4, 32'd4, 32'd1, 32'd0, 32'd12}) begin
            n_mis++;
            $display("FAIL mac_counts: req %0d evt %0d done %0d bias %0d done_cycle %0d want 4 4 1 0 12",
                req_n, evt_n, done_n, bias_n, done_k);
        end
        cyc();
        #1;
        n_cmp++;
        if ({state_o, busy_o} !== {3'd0, 1'b0}) begin
            n_mis++;
            $display("FAIL mac_back_idle: got %h want 0", {state_o, busy_o});
        end
    endtask

    task automatic test_mul();
        eng_acc_done_i = 1'b1;
        kick(2'd0, 16'd16, 16'd1, 16'd0);
        cyc();
        #1;
        n_cmp++;
        if ({state_o, snk_size_o, src_size_o, snk_req_start_o, src_req_start_o}
            !== {3'd1, 16'd16, 16'd1, 16'd16, 16'd16, 1'b1, 3'b011}) begin
            n_mis++;
            $display("FAIL mul_launch: got %h want %h",
                {state_o, snk_size_o, src_size_o, snk_req_start_o, src_req_start_o},
                {3'd1, 16'd16, 16'd1, 16'd16, 16'd16, 1'b1, 3'b011});
        end
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({state_o, evt_o} !== {3'd4, 1'b1}) begin
            n_mis++;
            $display("FAIL mul_update: got %h want %h", {state_o, evt_o}, {3'd4, 1'b1});
        end
        cyc();
        snk_ready_start_i = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, done_o, eng_enable_o, eng_clear_o} !== {3'd5, 1'b0, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL mul_term_hold: got %b want 101000", {state_o, done_o, eng_enable_o, eng_clear_o});
        end
        cyc();
        snk_ready_start_i = 1'b1;
        #1;
        n_cmp++;
        if ({state_o, done_o, err_o} !== {3'd5, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL mul_done: got %b want 10110", {state_o, done_o, err_o});
        end
        cyc();
        #1;
        n_cmp++;
        if ({state_o, done_o} !== {3'd0, 1'b0}) begin
            n_mis++;
            $display("FAIL mul_idle: got %b want 0000", {state_o, done_o});
        end
    endtask

    task automatic test_wait();
        eng_acc_done_i = 1'b0;
        src_ready_start_i = 3'b011;
        kick(2'd2, 16'd4, 16'd1, 16'd0);
        cyc();
        #1;
        n_cmp++;
        if ({state_o, src_req_start_o, snk_req_start_o, eng_start_o} !== {3'd1, 3'b000, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL wait_start: got %b want 0010000", {state_o, src_req_start_o, snk_req_start_o, eng_start_o});
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            n_cmp++;
            if ({state_o, eng_enable_o, eng_clear_o, src_req_start_o, snk_req_start_o}
                !== {3'd2, 1'b0, 1'b0, 3'b000, 1'b0}) begin
                n_mis++;
                $display("FAIL wait_hold[%0d]: got %b want 010000000", i,
                    {state_o, eng_enable_o, eng_clear_o, src_req_start_o, snk_req_start_o});
            end
        end
        cyc();
        src_ready_start_i = 3'b111;
        #1;
        n_cmp++;
        if ({state_o, src_req_start_o, snk_req_start_o, eng_start_o, eng_enable_o, src_size_o, snk_size_o}
            !== {3'd2, 3'b111, 1'b1, 1'b1, 1'b1, 16'd1, 16'd4, 16'd4, 16'd1}) begin
            n_mis++;
            $display("FAIL wait_release: got %h want %h",
                {state_o, src_req_start_o, snk_req_start_o, eng_start_o, eng_enable_o, src_size_o, snk_size_o},
                {3'd2, 3'b111, 1'b1, 1'b1, 1'b1, 16'd1, 16'd4, 16'd4, 16'd1});
        end
        cyc();
        eng_acc_done_i = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({state_o, done_o} !== {3'd5, 1'b1}) begin
            n_mis++;
            $display("FAIL wait_done: got %b want 1011", {state_o, done_o});
        end
        cyc();
        eng_acc_done_i = 1'b0;
    endtask

    task automatic test_timeout();
        eng_acc_done_i = 1'b0;
        kick(2'd1, 16'd2, 16'd1, 16'd10);
        cyc();
        #1;
        n_cmp++;
        if ({state_o, snk_req_start_o} !== {3'd1, 1'b1}) begin
            n_mis++;
            $display("FAIL tmo_launch: got %b want 0011", {state_o, snk_req_start_o});
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            n_cmp++;
            if (state_o !== 3'd3) begin
                n_mis++;
                $display("FAIL tmo_compute[%0d]: got %0d want 3", i, state_o);
            end
        end
        cyc();
        #1;
        n_cmp++;
        if ({state_o, done_o, err_o} !== {3'd5, 1'b1, 1'b1}) begin
            n_mis++;
            $display("FAIL tmo_term: got %b want 10111", {state_o, done_o, err_o});
        end
        cyc();
        #1;
        n_cmp++;
        if ({state_o, busy_o, err_o} !== {3'd0, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL tmo_err_sticky: got %b want 00001", {state_o, busy_o, err_o});
        end
    endtask

    task automatic test_abort();
        eng_acc_done_i = 1'b0;
        kick(2'd1, 16'd4, 16'd2, 16'd0);
        cyc();
        cyc();
        abort_i = 1'b1;
        eng_acc_done_i = 1'b1;
        #1;
        n_cmp++;
        if ({state_o, evt_o} !== {3'd3, 1'b0}) begin
            n_mis++;
            $display("FAIL abort_compute: got %b want 0110", {state_o, evt_o});
        end
        cyc();
        abort_i = 1'b0;
        eng_acc_done_i = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, evt_o, err_o, done_o, iter_o} !== {3'd5, 1'b0, 1'b1, 1'b1, 16'd0}) begin
            n_mis++;
            $display("FAIL abort_term: got %h want %h", {state_o, evt_o, err_o, done_o, iter_o},
                {3'd5, 1'b0, 1'b1, 1'b1, 16'd0});
        end
        kick(2'd1, 16'd4, 16'd1, 16'd0);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, err_o} !== {3'd1, 1'b0}) begin
            n_mis++;
            $display("FAIL abort_restart: got %b want 0010", {state_o, err_o});
        end
        eng_acc_done_i = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({state_o, done_o, err_o} !== {3'd5, 1'b1, 1'b0}) begin
            n_mis++;
            $display("FAIL abort_clean_done: got %b want 10110", {state_o, done_o, err_o});
        end
        cyc();
        eng_acc_done_i = 1'b0;
    endtask

    task automatic test_illegal();
        logic [1:0]  modes [3] = '{2'd3, 2'd1, 2'd0};
        logic [15:0] lens  [3] = '{16'd4, 16'd4, 16'd0};
        logic [15:0] iters [3] = '{16'd2, 16'd0, 16'd2};
        logic        errs  [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            kick(modes[i], lens[i], iters[i], 16'd0);
            cyc();
            #1;
            n_cmp++;
            if ({state_o, src_req_start_o, snk_req_start_o, eng_start_o, done_o, err_o}
                !== {3'd5, 3'b000, 1'b0, 1'b0, 1'b1, errs[i]}) begin
                n_mis++;
                $display("FAIL illegal[%0d]: got %b want %b", i,
                    {state_o, src_req_start_o, snk_req_start_o, eng_start_o, done_o, err_o},
                    {3'd5, 3'b000, 1'b0, 1'b0, 1'b1, errs[i]});
            end
            cyc();
        end
    endtask

    task automatic test_wrap_reset();
        int req_n = 0;
        logic [31:0] exp_a = 32'h0000_0020;
        cfg_base_i   = {32'h0000_0020, 32'h0, 32'h0, 32'h0};
        cfg_stride_i = {32'hFFFF_FFF0, 32'h0, 32'h0, 32'h0};
        eng_acc_done_i = 1'b1;
        kick(2'd1, 16'd4, 16'd4, 16'd0);
        for (int k = 0; k < 40 && !done_o; k++) begin
            cyc();
            #1;
            if (snk_req_start_o) begin
                n_cmp++;
                if (snk_addr_o !== exp_a) begin
                    n_mis++;
                    $display("FAIL wrap_addr[%0d]: got %h want %h", req_n, snk_addr_o, exp_a);
                end
                exp_a = exp_a + 32'hFFFF_FFF0;
                req_n++;
            end
        end
        n_cmp++;
        if (req_n != 4) begin
            n_mis++;
            $display("FAIL wrap_req_count: got %0d want 4", req_n);
        end
        cyc();
        kick(2'd1, 16'd4, 16'd4, 16'd0);
        cyc();
        cyc();
        cyc();
        cyc();
        #1;
        n_cmp++;
        if ({state_o, iter_o, snk_req_start_o} !== {3'd2, 16'd1, 1'b1}) begin
            n_mis++;
            $display("FAIL midjob_wait: got %h want %h", {state_o, iter_o, snk_req_start_o}, {3'd2, 16'd1, 1'b1});
        end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({state_o, iter_o, busy_o, src_req_start_o, snk_req_start_o, eng_start_o, done_o, evt_o, eng_clear_o}
            !== {3'd0, 16'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_mis++;
            $display("FAIL midjob_reset: got %h want %h",
                {state_o, iter_o, busy_o, src_req_start_o, snk_req_start_o, eng_start_o, done_o, evt_o, eng_clear_o},
                {3'd0, 16'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        cyc();
        rst_i = 1'b0;
        eng_acc_done_i = 1'b0;
    endtask

    task automatic test_clear();
        kick(2'd1, 16'd4, 16'd2, 16'd0);
        abort_i = 1'b0;
        cyc();
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        #1;
        n_cmp++;
        if ({state_o, busy_o, err_o, iter_o} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin
            n_mis++;
            $display("FAIL soft_clear: got %h want 0", {state_o, busy_o, err_o, iter_o});
        end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_i = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        cfg_mode_i = 2'd0;
        cfg_len_i = 16'd0;
        cfg_n_iter_i = 16'd0;
        cfg_timeout_i = 16'd0;
        cfg_base_i = '0;
        cfg_stride_i = '0;
        src_ready_start_i = 3'b111;
        snk_ready_start_i = 1'b1;
        eng_acc_done_i = 1'b0;

        test_reset();
        test_mac();
        test_mul();
        test_wait();
        test_timeout();
        test_abort();
        test_illegal();
        test_wrap_reset();
        test_clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
